// File: rtl/mem_pkg.sv
// Shared definitions for the memory access controller and the memory bench:
// default geometry and the controller FSM state encodings.
package mem_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_WR        = 3'd1;
    localparam state_t ST_RD_SETUP  = 3'd2;
    localparam state_t ST_RD_SAMPLE = 3'd3;
    localparam state_t ST_RESP      = 3'd4;
    localparam state_t ST_CLEAR     = 3'd5;

endpackage

// File: rtl/mem_access_ctrl.sv
// Single-port memory sequencer: one request at a time, plus a full-memory clear sweep.
// Latency: write occupies the memory 1 cycle after accept; read data valid 3 cycles after accept.
// Backpressure: req_ready only in idle; a held response (rsp_ready low) stalls all new requests.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              mem_enable,
    output logic              mem_readwrite,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_dataIn,
    input  logic [DATA_W-1:0] mem_dataOut
);

    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] rsp_addr_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [ADDR_W-1:0] addr_hold;

    logic              drv_en;
    logic              drv_rw;
    logic [ADDR_W-1:0] drv_addr;
    logic [DATA_W-1:0] drv_din;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            rsp_addr_q <= '0;
            rsp_data_q <= '0;
            addr_hold  <= '0;
        end else begin
            addr_hold <= drv_addr;
            case (state)
                ST_IDLE: begin
                    if (clear_start) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                    end else if (req_valid) begin
                        r_addr <= req_addr;
                        r_data <= req_data;
                        state  <= req_write ? ST_WR : ST_RD_SETUP;
                    end
                end
                ST_WR:        state <= ST_IDLE;
                ST_RD_SETUP:  state <= ST_RD_SAMPLE;
                ST_RD_SAMPLE: begin
                    rsp_data_q <= mem_dataOut;
                    rsp_addr_q <= r_addr;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) state <= ST_IDLE;
                end
                ST_CLEAR: begin
                    cnt <= cnt + ADDR_W'(1);
                    if (cnt == CNT_LAST) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Idle/response cycles park the address bus on its last value with reads selected.
    always_comb begin
        drv_en   = 1'b0;
        drv_rw   = 1'b1;
        drv_addr = addr_hold;
        drv_din  = '0;
        case (state)
            ST_WR: begin
                drv_en   = 1'b1;
                drv_rw   = 1'b0;
                drv_addr = r_addr;
                drv_din  = r_data;
            end
            ST_RD_SETUP, ST_RD_SAMPLE: begin
                drv_en   = 1'b1;
                drv_addr = r_addr;
            end
            ST_CLEAR: begin
                drv_en   = 1'b1;
                drv_rw   = 1'b0;
                drv_addr = cnt;
            end
            default: ;
        endcase
    end

    // Reset masks every output immediately, so a reset landing mid-sweep or
    // mid-write never lets the in-flight memory write through.
    assign mem_enable    = !rst && drv_en;
    assign mem_readwrite = rst || drv_rw;
    assign mem_address   = rst ? '0 : drv_addr;
    assign mem_dataIn    = rst ? '0 : drv_din;

    assign req_ready  = !rst && (state == ST_IDLE) && !clear_start;
    assign rsp_valid  = !rst && (state == ST_RESP);
    assign rsp_data   = rst ? '0 : rsp_data_q;
    assign rsp_addr   = rst ? '0 : rsp_addr_q;
    assign clear_busy = !rst && (state == ST_CLEAR);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: behavioural memory, shadow model and response scoreboard.
module tb_mem_access_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_write;
    logic [5:0] req_addr;
    logic [3:0] req_data;
    logic       rsp_valid, rsp_ready;
    logic [3:0] rsp_data;
    logic [5:0] rsp_addr;
    logic       clear_start, clear_busy;
    logic       mem_enable, mem_readwrite;
    logic [5:0] mem_address;
    logic [3:0] mem_dataIn, mem_dataOut;

    mem_access_ctrl #(.ADDR_W(6), .DATA_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_addr(rsp_addr),
        .clear_start(clear_start), .clear_busy(clear_busy),
        .mem_enable(mem_enable), .mem_readwrite(mem_readwrite),
        .mem_address(mem_address), .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
    );

    always #5 clk = ~clk;

    // Behavioural memory: combinational read, write on rising edge.
    logic       mem_init;
    logic [3:0] mem [64];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 4'(i * 3 + 1);
        end else if (mem_enable === 1'b1 && mem_readwrite === 1'b0) begin
            mem[mem_address] <= mem_dataIn;
        end
    end
    assign mem_dataOut = mem[mem_address];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int nwr = 0;
    int exp_wr = 0;
    logic [3:0] sh [64];

    typedef struct {
        logic [5:0] a;
        logic [3:0] d;
        int         t;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_enable === 1'b1 && mem_readwrite === 1'b0) nwr <= nwr + 1;
    end

    // Response scoreboard: checks data/addr every valid cycle (stability) and latency on the first.
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                if (!prev_v) chk("rsp_latency", 32'(cyc - q[0].t), 32'd3);
                chk("rsp_data", 32'(rsp_data), 32'(q[0].d));
                chk("rsp_addr", 32'(rsp_addr), 32'(q[0].a));
                if (rsp_ready) void'(q.pop_front());
            end
        end
        prev_v <= (rsp_valid === 1'b1);
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic wr, input logic [5:0] a, input logic [3:0] d);
        bit got = 0;
        exp_t e;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_data  = d;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (req_ready === 1'b1) got = 1;
        end
        chk("req_accept", 32'(got), 32'd1);
        if (got) begin
            if (wr) begin
                sh[a] = d;
                exp_wr++;
            end else begin
                e.a = a;
                e.d = sh[a];
                e.t = cyc;
                q.push_back(e);
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = ~wr;
        req_addr  = ~a;
        req_data  = ~d;
    endtask

    task automatic wr(input logic [5:0] a, input logic [3:0] d);
        issue(1'b1, a, d);
        @(negedge clk);
        chk("wr_en", 32'(mem_enable), 32'd1);
        chk("wr_rw", 32'(mem_readwrite), 32'd0);
        chk("wr_addr", 32'(mem_address), 32'(a));
        chk("wr_din", 32'(mem_dataIn), 32'(d));
        chk("wr_busy_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 50; n++) begin
            if (q.size() == 0) break;
            @(posedge clk);
        end
        chk("rsp_drain", 32'(q.size()), 32'd0);
        #1;
    endtask

    task automatic rd_issue(input logic [5:0] a);
        issue(1'b0, a, 4'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rd_en", 32'(mem_enable), 32'd1);
            chk("rd_rw", 32'(mem_readwrite), 32'd1);
            chk("rd_addr", 32'(mem_address), 32'(a));
            chk("rd_busy_ready", 32'(req_ready), 32'd0);
        end
    endtask

    task automatic rd(input logic [5:0] a);
        rd_issue(a);
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [5:0] ra;
        logic [3:0] rdat;
        rst = 1'b1; mem_init = 1'b1; rsp_ready = 1'b1; clear_start = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
        for (int i = 0; i < 64; i++) sh[i] = 4'(i * 3 + 1);

        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_mem_en", 32'(mem_enable), 32'd0);
        chk("rst_mem_rw", 32'(mem_readwrite), 32'd1);
        @(posedge clk); #1 mem_init = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("post_rst_rsp_addr", 32'(rsp_addr), 32'd0);
        chk("post_rst_clear_busy", 32'(clear_busy), 32'd0);
        chk("post_rst_mem_addr", 32'(mem_address), 32'd0);
        chk("post_rst_mem_din", 32'(mem_dataIn), 32'd0);
        @(posedge clk); #1;

        // Basic writes then reads back-to-back.
        wr(6'd1, 4'b1010);
        wr(6'd2, 4'b1100);
        wr(6'd3, 4'b0101);
        rd(6'd1);
        rd(6'd2);
        rd(6'd3);

        // Held response; clear_start while stalled must be ignored.
        rsp_ready = 1'b0;
        rd_issue(6'd2);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_ready", 32'(req_ready), 32'd0);
            chk("stall_mem_en", 32'(mem_enable), 32'd0);
            clear_start = (i == 1);
        end
        clear_start = 1'b0;
        @(posedge clk); #1 rsp_ready = 1'b1;
        wait_drain();
        @(negedge clk);
        chk("stall_no_clear", 32'(clear_busy), 32'd0);
        chk("stall_idle_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        // Reset during RD_SAMPLE: response abandoned.
        issue(1'b0, 6'd3, 4'h0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        q.delete();
        chk("rst_rd_ready", 32'(req_ready), 32'd0);
        chk("rst_rd_mem_en", 32'(mem_enable), 32'd0);
        chk("rst_rd_mem_addr", 32'(mem_address), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rd_after_ready", 32'(req_ready), 32'd1);
        chk("rst_rd_after_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rd_after_rsp_addr", 32'(rsp_addr), 32'd0);
        repeat (4) begin
            @(negedge clk);
            chk("rst_rd_no_valid", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        rd(6'd3);

        // Clear wins over a simultaneous write request.
        clear_start = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 6'd5; req_data = 4'hF;
        @(negedge clk);
        chk("clr_blocks_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        clear_start = 1'b0; req_valid = 1'b0;
        for (int i = 0; i < 64; i++) sh[i] = 4'h0;
        exp_wr += 64;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            clear_start = 1'b0;
            if (clear_busy !== 1'b1) break;
            n++;
            if (n == 1) chk("clr_first_addr", 32'(mem_address), 32'd0);
            if (n == 30) begin
                chk("clr_mid_ready", 32'(req_ready), 32'd0);
                clear_start = 1'b1;
            end
            if (n == 64) begin
                chk("clr_last_addr", 32'(mem_address), 32'd63);
                chk("clr_last_din", 32'(mem_dataIn), 32'd0);
            end
        end
        chk("clr_len", 32'(n), 32'd64);
        @(posedge clk); #1;
        rd(6'd5);
        rd(6'd63);

        // Reset during clear at counter 10.
        wr(6'd9, 4'h6);
        wr(6'd10, 4'hD);
        wr(6'd20, 4'h7);
        wr(6'd63, 4'h3);
        clear_start = 1'b1;
        @(posedge clk); #1 clear_start = 1'b0;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (clear_busy === 1'b1 && mem_address == 6'd10) begin
                n = 1;
                break;
            end
        end
        chk("clr10_reached", 32'(n), 32'd1);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) sh[i] = 4'h0;
        exp_wr += 10;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("clr10_busy", 32'(clear_busy), 32'd0);
        chk("clr10_mem_en", 32'(mem_enable), 32'd0);
        chk("clr10_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        rd(6'd9);
        rd(6'd10);
        rd(6'd20);
        rd(6'd63);

        // Random write/read-back pairs.
        for (int i = 0; i < 8; i++) begin
            ra = 6'($urandom_range(0, 63));
            rdat = 4'($urandom_range(0, 15));
            wr(ra, rdat);
            rd(ra);
            rd(6'($urandom_range(0, 63)));
        end

        repeat (2) @(posedge clk);
        #1;
        chk("mem_write_count", 32'(nwr), 32'(exp_wr));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 6, memory address width (64 words).
REQ-002 Parameter DATA_W, default 4, memory data width.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  request offered.
REQ-006 req_ready  output  1  request accepted when req_valid && req_ready at a clk edge.
REQ-007 req_write  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  ADDR_W  request address.
REQ-009 req_data  input  DATA_W  write data.
REQ-010 rsp_valid  output  1  read data available.
REQ-011 rsp_ready  input  1  consumer takes response when rsp_valid && rsp_ready.
REQ-012 rsp_data  output  DATA_W  read data.
REQ-013 rsp_addr  output  ADDR_W  address of returned data.
REQ-014 clear_start  input  1  pulse: zero the whole memory.
REQ-015 clear_busy  output  1  clear sweep in progress.
REQ-016 mem_enable, mem_readwrite  output  1 each  to the memory; readwrite 0 = write, 1 = read.
REQ-017 mem_address  output  ADDR_W;  mem_dataIn  output  DATA_W;  mem_dataOut  input  DATA_W.

Function
REQ-018 FSM states: IDLE, WR, RD_SETUP, RD_SAMPLE, RESP, CLEAR.
REQ-019 req_ready SHALL be 1 only in IDLE with clear_start low.
REQ-020 IDLE: clear_start=1 -> CLEAR, counter=0; else accepted write -> WR; accepted read -> RD_SETUP. clear_start wins over simultaneous req_valid; that request is not accepted.
REQ-021 Request fields SHALL be registered at acceptance; later req_* changes have no effect.
REQ-022 WR: mem_enable=1, mem_readwrite=0, mem_address/mem_dataIn = registered values for exactly one cycle, then IDLE.
REQ-023 RD_SETUP: mem_enable=1, mem_readwrite=1, mem_address = registered address; next RD_SAMPLE.
REQ-024 RD_SAMPLE: same drive; mem_dataOut captured into rsp_data at the exiting edge; next RESP.
REQ-025 RESP: rsp_valid=1, mem_enable=0; rsp_data/rsp_addr stable until rsp_ready=1, then IDLE.
REQ-026 Read latency: rsp_valid high 3 cycles after the accepting edge (accept, SETUP, SAMPLE, RESP); back-to-back throughput is one request per 2 cycles (writes) or 4+ cycles (reads).
REQ-027 CLEAR: mem_enable=1, mem_readwrite=0, mem_dataIn=0, mem_address=counter; counter increments each cycle; after address 2^ADDR_W-1 is written (64 cycles) -> IDLE; counter wraps to 0, never exceeds range.
REQ-028 clear_busy SHALL be 1 exactly in CLEAR; clear_start during CLEAR or any non-IDLE state is ignored.
REQ-029 In IDLE and RESP: mem_enable=0, mem_readwrite=1, mem_dataIn=0, mem_address holds last value.
REQ-030 No write SHALL reach the memory except in WR or CLEAR.

Reset
REQ-031 rst=1 at an edge -> IDLE, counter=0, registered request cleared; any in-progress write, read or clear is abandoned and no response is produced.
REQ-032 Output values under reset: req_ready=0 while rst high, 1 on first cycle after; rsp_valid=0, rsp_data=0, rsp_addr=0, clear_busy=0, mem_enable=0, mem_readwrite=1, mem_address=0, mem_dataIn=0.

Structure
REQ-033 Package mem_pkg SHALL hold ADDR_W/DATA_W defaults and the FSM state enum; shared with the memory bench.
REQ-034 Single module; clear counter and FSM inline, no sub-module.

Verification
REQ-035 Writes 1<-1010, 2<-1100, 3<-0101 then reads 1,2,3 with rsp_ready=1 -> rsp_data 1010, 1100, 0101 with matching rsp_addr, each 3 cycles after acceptance.
REQ-036 Read addr 2 with rsp_ready=0 for 5 cycles -> rsp_valid held, rsp_data=1100 stable, req_ready=0 until handshake.
REQ-037 clear_start and req_valid (write 5<-1111) same cycle -> request not accepted, clear_busy high 64 cycles, then read 5 and 63 -> 0000.
REQ-038 rst asserted in CLEAR at counter 10 -> next cycle IDLE, clear_busy=0, mem_enable=0; addresses >=10 retain prior data.
REQ-039 rst asserted in RD_SAMPLE -> rsp_valid never asserts; subsequent read of same address returns correct data.
REQ-040 Monitor: mem_enable&&!mem_readwrite only in WR/CLEAR; req_ready never high outside IDLE.
